// File: rtl/fft_out_reorder_if.sv
// ---------------------------------------------------------------------------
// fft_out_reorder_if
// Sample-stream bundle around the FFT output reorder buffer.
//   di_en/di_re/di_im      : input stream from the R2SDF FFT (bit-reversed order)
//   do_en/do_re/do_im      : output stream in natural bin order
//   do_sof                 : marks bin 0 of each output frame
//   do_idx                 : bin index of the current output sample
// Modports:
//   master : the side that feeds samples in and watches the output stream
//   slave  : the reorder buffer itself
// ---------------------------------------------------------------------------
interface fft_out_reorder_if #(
    parameter int DW   = 16,
    parameter int LOGN = 4
);
    logic                  di_en;
    logic signed [DW-1:0]  di_re;
    logic signed [DW-1:0]  di_im;
    logic                  do_en;
    logic signed [DW-1:0]  do_re;
    logic signed [DW-1:0]  do_im;
    logic                  do_sof;
    logic [LOGN-1:0]       do_idx;

    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im, do_sof, do_idx
    );

    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im, do_sof, do_idx
    );
endinterface

// File: rtl/fft_out_reorder.sv
// ---------------------------------------------------------------------------
// fft_out_reorder
// Ping-pong frame buffer that turns the bit-reversed output stream of an
// R2SDF FFT into natural bin order. One bank fills while the other drains;
// the input may stall at will, the output drains a full frame in N
// back-to-back cycles.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rstn  : asynchronous active-low reset; discards any partial/pending frame
//   bus   : fft_out_reorder_if.slave (di_* in, do_* out)
//
// Build option:
//   FFT_REORDER_BITREV_EN defined   -> write address is bitrev(wr_cnt),
//                                      output comes out in natural order
//   FFT_REORDER_BITREV_EN undefined -> write address is wr_cnt, the block is
//                                      a plain frame-aligned double buffer
//                                      with identical timing
// ---------------------------------------------------------------------------
module fft_out_reorder #(
    parameter int DW   = 16,
    parameter int N    = 16,
    parameter int LOGN = 4
) (
    input  logic              clk,
    input  logic              rstn,
    fft_out_reorder_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [LOGN-1:0]   wr_cnt;
    logic [LOGN-1:0]   wr_addr;
    logic              wr_bank;
    logic              wr_last;
    logic [1:0]        full, full_nxt;
    logic              arm;
    logic [LOGN-1:0]   rd_cnt, rd_cnt_nxt;
    logic              rd_bank, rd_bank_nxt;
    logic              rd_done;
    logic              other_ready;
    logic              vld_p0;
    logic [2*DW-1:0]   rd_data_p0;
    logic [2*DW-1:0]   mem [2*N];

`ifdef FFT_REORDER_BITREV_EN
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
        return r;
    endfunction

    assign wr_addr = bitrev(wr_cnt);
`else
    assign wr_addr = wr_cnt;
`endif

    assign wr_last = bus.di_en && (wr_cnt == LOGN'(N-1));
    assign rd_done = (state == READ) && (rd_cnt == LOGN'(N-1));

    // Write side: bank contents carry no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (bus.di_en) mem[{wr_bank, wr_addr}] <= {bus.di_re, bus.di_im};
    end

    // A bank finishing its drain and the other bank finishing its fill can
    // land on the same edge; the set of the filled bank must not be lost.
    always_comb begin
        full_nxt = full;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
        if (wr_last) full_nxt[wr_bank] = 1'b1;
    end

    // Reader FSM. From IDLE the start waits one extra edge (arm) so that a
    // frame always emerges exactly three edges after its last sample; the
    // back-to-back restart in READ sees a fill completing on this very edge.
    always_comb begin
        state_nxt   = state;
        rd_bank_nxt = rd_bank;
        rd_cnt_nxt  = rd_cnt;
        other_ready = full[~rd_bank] || (wr_last && (wr_bank == ~rd_bank));
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt   = READ;
                    // Both full only after a stall upstream: the older frame
                    // sits in the bank the writer is pointing at again.
                    rd_bank_nxt = (full[0] && full[1]) ? wr_bank : full[1];
                    rd_cnt_nxt  = '0;
                end
            end
            READ: begin
                rd_cnt_nxt = rd_cnt + 1'b1;
                if (rd_done) begin
                    if (other_ready) rd_bank_nxt = ~rd_bank;
                    else             state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            arm     <= 1'b0;
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            state   <= state_nxt;
            rd_cnt  <= rd_cnt_nxt;
            rd_bank <= rd_bank_nxt;
            arm     <= (state == IDLE) && (full != 2'b00);
            if (bus.di_en) wr_cnt <= wr_cnt + 1'b1;
            if (wr_last)   wr_bank <= ~wr_bank;
            full    <= full_nxt;
        end
    end

    // ---- stage p0: read address / raw read data ----
    assign vld_p0     = (state == READ);
    assign rd_data_p0 = mem[{rd_bank, rd_cnt}];

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.do_en  <= 1'b0;
            bus.do_re  <= '0;
            bus.do_im  <= '0;
            bus.do_sof <= 1'b0;
            bus.do_idx <= '0;
        end else begin
            bus.do_en  <= vld_p0;
            bus.do_sof <= vld_p0 && (rd_cnt == '0);
            bus.do_idx <= vld_p0 ? rd_cnt : '0;
            if (vld_p0) begin
                bus.do_re <= rd_data_p0[2*DW-1:DW];
                bus.do_im <= rd_data_p0[DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_out_reorder
// Directed bench for fft_out_reorder (N=16). Expected bin order follows the
// build option FFT_REORDER_BITREV_EN: bitrev(k) when defined, k otherwise.
// ---------------------------------------------------------------------------
module tb_fft_out_reorder;
    localparam int DW   = 16;
    localparam int N    = 16;
    localparam int LOGN = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    fft_out_reorder_if #(.DW(DW), .LOGN(LOGN)) bus ();

    fft_out_reorder #(.DW(DW), .N(N), .LOGN(LOGN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_acc = 0;

    int q_re[$];
    int q_im[$];
    int q_idx[$];
    int q_sof[$];
    int q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.do_en === 1'b1) begin
            q_re.push_back(int'(bus.do_re));
            q_im.push_back(int'(bus.do_im));
            q_idx.push_back(int'(bus.do_idx));
            q_sof.push_back(int'(bus.do_sof));
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int perm(input int k);
        int r;
        r = k;
`ifdef FFT_REORDER_BITREV_EN
        r = 0;
        for (int i = 0; i < LOGN; i++) if (k[i]) r |= (1 << (LOGN - 1 - i));
`endif
        return r;
    endfunction

    task automatic drive(input logic en, input int re, input int im);
        bus.di_en = en;
        bus.di_re = DW'(re);
        bus.di_im = DW'(im);
        @(posedge clk);
        #1;
        if (en) last_acc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_do_en"},  bus.do_en,  0);
        chk({tag, "_do_re"},  bus.do_re,  0);
        chk({tag, "_do_im"},  bus.do_im,  0);
        chk({tag, "_do_sof"}, bus.do_sof, 0);
        chk({tag, "_do_idx"}, bus.do_idx, 0);
    endtask

    // lat_ref: edge that accepted the last sample of the first expected frame.
    task automatic check_frames(input string tag, input int nf, input int base,
                                input bit neg_im, input int lat_ref);
        int f, k, er;
        chk({tag, "_count"}, q_re.size(), N * nf);
        for (int i = 0; i < q_re.size() && i < N * nf; i++) begin
            f  = i / N;
            k  = i % N;
            er = base + N * f + perm(k);
            chk($sformatf("%s_re[%0d]", tag, i),  q_re[i],  er);
            chk($sformatf("%s_im[%0d]", tag, i),  q_im[i],  neg_im ? -er : 0);
            chk($sformatf("%s_idx[%0d]", tag, i), q_idx[i], k);
            chk($sformatf("%s_sof[%0d]", tag, i), q_sof[i], (k == 0) ? 1 : 0);
            chk($sformatf("%s_cyc[%0d]", tag, i), q_cyc[i], lat_ref + 3 + i);
        end
        q_re.delete();
        q_im.delete();
        q_idx.delete();
        q_sof.delete();
        q_cyc.delete();
    endtask

    initial begin
        int a;
        rstn      = 1'b0;
        bus.di_en = 1'b0;
        bus.di_re = '0;
        bus.di_im = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rstn = 1'b1;
        idle(2);

        // Single continuous frame, im = 0.
        for (int i = 0; i < N; i++) drive(1'b1, i, 0);
        a = last_acc;
        idle(24);
        check_frames("t1", 1, 0, 1'b0, a);
        // Idle output: data holds last bin, index/sof/valid low.
        chk("hold_re",  bus.do_re,  perm(N - 1));
        chk("hold_en",  bus.do_en,  0);
        chk("hold_idx", bus.do_idx, 0);
        chk("hold_sof", bus.do_sof, 0);

        // Two back-to-back frames, negative imaginary parts.
        for (int i = 0; i < 2 * N; i++) drive(1'b1, i, -i);
        a = last_acc - N;
        idle(40);
        check_frames("t2", 2, 0, 1'b1, a);

        // Input valid every other cycle.
        for (int i = 0; i < N; i++) begin
            drive(1'b1, i, -i);
            drive(1'b0, 0, 0);
        end
        a = last_acc;
        idle(24);
        check_frames("t3", 1, 0, 1'b1, a);

        // Reset part way through a frame, then a clean frame.
        for (int i = 0; i < 7; i++) drive(1'b1, 200 + i, 0);
        bus.di_en = 1'b0;
        rstn = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        idle(3);
        check_zero_outputs("in_rst");
        rstn = 1'b1;
        idle(1);
        for (int i = 0; i < N; i++) drive(1'b1, 100 + i, -(100 + i));
        a = last_acc;
        idle(30);
        check_frames("t4", 1, 100, 1'b1, a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning sample width of each real/imaginary component.
REQ-002 The block SHALL have parameter N, default 16, meaning FFT points per frame (power of two, 4..1024).
REQ-003 The block SHALL have parameter LOGN, default 4, meaning log2(N).
REQ-004 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port di_en  input  1  input sample valid (R2SDF FFT output stream, bit-reversed order).
REQ-007 The block SHALL have port di_re  input  DW  input real part, two's complement.
REQ-008 The block SHALL have port di_im  input  DW  input imaginary part, two's complement.
REQ-009 The block SHALL have port do_en  output  1  output sample valid, natural order.
REQ-010 The block SHALL have port do_re  output  DW  output real part.
REQ-011 The block SHALL have port do_im  output  DW  output imaginary part.
REQ-012 The block SHALL have port do_sof  output  1  high with do_en on bin 0 of each output frame.
REQ-013 The block SHALL have port do_idx  output  LOGN  bin index of current output sample.

Function
REQ-014 The block SHALL hold two N-entry banks (ping-pong) of 2*DW bits each.
REQ-015 Write counter wr_cnt (LOGN bits) SHALL increment by one per cycle with di_en=1 and hold when di_en=0; gaps of any length allowed mid-frame.
REQ-016 Each accepted sample SHALL be written to bank wr_bank at address bitrev(wr_cnt) (bit i of address = bit LOGN-1-i of wr_cnt).
REQ-017 When a sample is accepted with wr_cnt=N-1, wr_cnt SHALL wrap to 0, wr_bank SHALL toggle, and the just-filled bank's full flag SHALL set.
REQ-018 Reader FSM SHALL have states IDLE and READ; IDLE->READ at the edge after a full flag is seen set, selecting that bank, rd_cnt=0.
REQ-019 In READ, rd_cnt SHALL increment every cycle unconditionally; at rd_cnt=N-1 the bank's full flag SHALL clear and FSM SHALL go to IDLE, or directly restart READ on the other bank if its full flag is set (including set on that same edge).
REQ-020 Read data SHALL be registered: do_en/do_re/do_im/do_idx SHALL appear one cycle after the read address; do_idx=rd_cnt delayed one cycle; do_sof=1 iff do_en=1 and do_idx=0.
REQ-021 Latency SHALL be exactly 3 rising edges from the edge accepting the last sample of a frame to the edge presenting bin 0 with do_en=1; each frame SHALL then output N consecutive do_en=1 cycles, back-to-back frames with no gap.
REQ-022 Since input rate <=1 sample/cycle and output drains in N cycles, a bank SHALL never be overwritten before read; no back-pressure exists.
REQ-023 With do_en=0, do_re/do_im SHALL hold their last value; do_idx and do_sof SHALL be 0.
REQ-024 No arithmetic SHALL be applied to data; output values SHALL equal input values bit-exact.

Reset
REQ-025 On rstn=0, asynchronously: do_en=0, do_re=0, do_im=0, do_sof=0, do_idx=0, wr_cnt=0, wr_bank=0, rd_cnt=0, both full flags=0, FSM=IDLE.
REQ-026 Reset mid-frame or mid-read SHALL discard the partial/pending frame; bank contents need not be cleared.

Configuration
REQ-027 Macro FFT_REORDER_BITREV_EN defined: write address SHALL be bitrev(wr_cnt) (natural-order output).
REQ-028 Macro FFT_REORDER_BITREV_EN undefined: write address SHALL be wr_cnt unchanged; block becomes a frame-aligned double buffer, timing identical.

Verification
REQ-029 N=16, macro defined, 16 continuous samples di_re=0..15, di_im=0 -> do_re sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, do_sof on first only, do_en first high 3 edges after last input.
REQ-030 Two back-to-back frames di_re=0..31 continuous -> 32 consecutive do_en cycles, second frame 16,24,20,...,31, do_sof twice 16 cycles apart.
REQ-031 di_en toggling 1/0 each cycle for 32 cycles (16 samples 0..15) -> single contiguous 16-cycle do_en burst, same order as REQ-029.
REQ-032 rstn pulsed low after 7 samples of a frame, then full frame 100..115 -> only one output frame, bins = 100+bitrev(k), all outputs 0 during reset.
REQ-033 Macro undefined, input 0..15 -> output 0..15 in order, same latency as REQ-029.
